// File: rtl/fpm_seq_core.sv
// fpm_seq_core: multi-cycle floating-point multiplier with a start/done handshake.
// The mantissa product comes from an iterative shift-add multiplier, one
// multiplier bit per cycle. NORM then normalizes, rounds, classifies and
// registers the result.
// Build option: define FPM_ROUND_EN for round-to-nearest-even. Without it the
// fraction is truncated and no guard/sticky logic exists. Latency is the same
// in both builds.
module fpm_seq_core #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                start_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]   a_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]   b_in,
  output logic                                busy_out,
  output logic                                done_out,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0]   fpm_out,
  output logic                                overflow_out,
  output logic                                underflow_out
);

  localparam int MW = MANTISSA_WIDTH;
  localparam int EW = EXP_WIDTH;
  localparam int W  = EW + MW + 1;
  localparam int N  = MW + 1;
  localparam int P  = 2 * N;
  localparam int XW = EW + 2;
  localparam int CW = $clog2(N);
  localparam logic signed [XW-1:0] BIAS    = XW'((1 << (EW - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_TOP = XW'((1 << EW) - 1);

  typedef enum logic [1:0] {IDLE, MULT, NORM} state_t;

  state_t                state_q, state_d;
  logic                  sign_q, sign_d;
  logic                  zero_q, zero_d;
  logic signed [XW-1:0]  exp_q, exp_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [P-1:0]          acc_q, acc_d;
  logic [P-1:0]          mcand_q, mcand_d;
  logic [N-1:0]          mplier_q, mplier_d;
  logic                  done_q, done_d;
  logic [W-1:0]          res_q, res_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic                  nshift;
  logic [N-1:0]          nmant;
  logic [N:0]            rmant;
  logic [MW-1:0]         nfrac;
  logic signed [XW-1:0]  nexp;

`ifdef FPM_ROUND_EN
  logic                  guard;
  logic                  sticky;

  // Round half to even: increment when above half, or on an exact tie with odd LSB.
  function automatic logic [N:0] round_mant(input logic [N-1:0] m, input logic g,
                                            input logic s);
    return {1'b0, m} + {{N{1'b0}}, g & (s | m[0])};
  endfunction
`else
  // Truncation: the kept bits pass through unchanged.
  function automatic logic [N:0] round_mant(input logic [N-1:0] m);
    return {1'b0, m};
  endfunction
`endif

  // Normalize the finished product, round it and fold carries into the exponent.
  always_comb begin
    nshift = acc_q[P-1];
    nmant  = nshift ? acc_q[P-1:N] : acc_q[P-2:N-1];
`ifdef FPM_ROUND_EN
    guard  = nshift ? acc_q[N-1] : acc_q[N-2];
    sticky = nshift ? |acc_q[N-2:0] : |acc_q[N-3:0];
    rmant  = round_mant(nmant, guard, sticky);
`else
    rmant  = round_mant(nmant);
`endif
    nfrac  = rmant[N] ? rmant[MW:1] : rmant[MW-1:0];
    nexp   = exp_q + $signed(XW'(nshift)) + $signed(XW'(rmant[N]));
  end

  // Next-state logic for the FSM and the datapath it steers.
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    zero_d   = zero_q;
    exp_d    = exp_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    done_d   = 1'b0;
    res_d    = res_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          sign_d   = a_in[W-1] ^ b_in[W-1];
          zero_d   = (a_in[W-2:MW] == '0) || (b_in[W-2:MW] == '0);
          exp_d    = $signed({2'b00, a_in[W-2:MW]}) + $signed({2'b00, b_in[W-2:MW]}) - BIAS;
          cnt_d    = CW'(MW);
          acc_d    = '0;
          mcand_d  = P'({1'b1, a_in[MW-1:0]});
          mplier_d = {1'b1, b_in[MW-1:0]};
          state_d  = MULT;
        end
      end
      MULT: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == '0) state_d = NORM;
        else             cnt_d   = cnt_q - 1'b1;
      end
      NORM: begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (zero_q) begin
          res_d = {sign_q, {(W-1){1'b0}}};
        end else if (nexp >= EXP_TOP) begin
          res_d = {sign_q, {EW{1'b1}}, {MW{1'b0}}};
          ovf_d = 1'b1;
        end else if (nexp <= 0) begin
          res_d = {sign_q, {(W-1){1'b0}}};
          unf_d = 1'b1;
        end else begin
          res_d = {sign_q, nexp[EW-1:0], nfrac};
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      exp_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      done_q   <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      done_q   <= done_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign busy_out      = (state_q != IDLE);
  assign done_out      = done_q;
  assign fpm_out       = res_q;
  assign overflow_out  = ovf_q;
  assign underflow_out = unf_q;

endmodule

// File: tb/tb_fpm_seq_core.sv
// Testbench for fpm_seq_core with default parameters (binary32 format).
// It uses fixed vectors, a reference model for random operands, and
// directed protocol sequences.
module tb_fpm_seq_core;

  logic        clock;
  logic        reset_n;
  logic        start_in;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy_out;
  logic        done_out;
  logic [31:0] fpm_out;
  logic        overflow_out;
  logic        underflow_out;

  int total = 0;
  int bad   = 0;

  fpm_seq_core dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start_in     (start_in),
    .a_in         (a_in),
    .b_in         (b_in),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .fpm_out      (fpm_out),
    .overflow_out (overflow_out),
    .underflow_out(underflow_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        o;
    logic        u;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference product: exact integer product of the significands, then
  // quotient/remainder for normalization and rounding.
  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ovf, output logic unf);
    logic              s;
    int                e;
    int                sh;
    longint unsigned   prod;
    longint unsigned   q;
`ifdef FPM_ROUND_EN
    longint unsigned   rem;
    longint unsigned   half;
`endif
    s   = a[31] ^ b[31];
    ovf = 1'b0;
    unf = 1'b0;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
      r = {s, 31'b0};
      return;
    end
    prod = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
    e    = int'(a[30:23]) + int'(b[30:23]) - 127;
    sh   = 23;
    if (prod >= (64'd1 << 47)) begin
      sh = 24;
      e  = e + 1;
    end
    q = prod >> sh;
`ifdef FPM_ROUND_EN
    rem  = prod - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
`endif
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) begin
      r   = {s, 8'hFF, 23'b0};
      ovf = 1'b1;
    end else if (e <= 0) begin
      r   = {s, 31'b0};
      unf = 1'b1;
    end else begin
      r = {s, 8'(e), q[22:0]};
    end
  endfunction

  // Starts an operation. It must be called #1 after a rising edge, and it returns #1
  // after the done edge. If poke >= 0, a second start with other operands is driven at that cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                        input logic eo, input logic eu, input int poke, input string tag);
    int   n;
    logic got;
    logic busy_ok;
    a_in     = a;
    b_in     = b;
    start_in = 1'b1;
    @(posedge clock); #1;
    start_in = 1'b0;
    busy_ok  = busy_out;
    n        = 0;
    got      = 1'b0;
    while (n < 60 && !got) begin
      if (n == poke) begin
        start_in = 1'b1;
        a_in     = ~a;
        b_in     = ~b;
      end else begin
        start_in = 1'b0;
      end
      @(posedge clock); #1;
      n++;
      if (done_out) got = 1'b1;
      else if (!busy_out) busy_ok = 1'b0;
    end
    start_in = 1'b0;
    if (!got) $display("FAIL %s_timeout: no done_out within 60 cycles", tag);
    chk({tag, "_latency"}, 32'(n), 32'd25);
    chk({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy_out), 32'd0);
    chk({tag, "_result"}, fpm_out, er);
    chk({tag, "_ovf"}, 32'(overflow_out), 32'(eo));
    chk({tag, "_unf"}, 32'(underflow_out), 32'(eu));
  endtask

  // Checks that done lasts one cycle and that the result holds afterwards.
  task automatic after_done(input logic [31:0] er, input string tag);
    @(posedge clock); #1;
    chk({tag, "_done_pulse"}, 32'(done_out), 32'd0);
    chk({tag, "_held"}, fpm_out, er);
  endtask

  vec_t        vecs[7];
  logic [31:0] ra, rb, rr;
  logic        ro, ru;
  logic        saw_done;

  initial begin
    vecs[0] = '{32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0};
    vecs[1] = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0};
    vecs[2] = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0};
    vecs[3] = '{32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1};
    vecs[4] = '{32'h00000000, 32'hC0400000, 32'h80000000, 1'b0, 1'b0};
`ifdef FPM_ROUND_EN
    vecs[5] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 1'b0, 1'b0};
`else
    vecs[5] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00001, 1'b0, 1'b0};
`endif
    vecs[6] = '{32'h7F800000, 32'h3E800000, 32'h7E800000, 1'b0, 1'b0};

    reset_n  = 1'b0;
    start_in = 1'b0;
    a_in     = '0;
    b_in     = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_busy", 32'(busy_out), 32'd0);
    chk("reset_done", 32'(done_out), 32'd0);
    chk("reset_fpm", fpm_out, 32'd0);
    chk("reset_flags", 32'({overflow_out, underflow_out}), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Fixed vectors; even-indexed entries chain straight into the next start.
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].o, vecs[i].u, -1, $sformatf("vec%0d", i));
      if (i % 2 == 1 || i == 6) after_done(vecs[i].r, $sformatf("vec%0d", i));
    end

    // Random operands, checked against the reference model.
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 != 0) begin
        ra[30:23] = 8'($urandom_range(90, 165));
        rb[30:23] = 8'($urandom_range(90, 165));
      end
      ref_mul(ra, rb, rr, ro, ru);
      run_op(ra, rb, rr, ro, ru, -1, $sformatf("rnd%0d", i));
    end
    after_done(rr, "rnd_last");

    // A start pulse while busy must not disturb the operation.
    run_op(32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0, 10, "poke");
    after_done(32'hC0C00000, "poke");
    saw_done = 1'b0;
    repeat (30) begin
      @(posedge clock); #1;
      if (done_out || busy_out) saw_done = 1'b1;
    end
    chk("poke_no_second_op", 32'(saw_done), 32'd0);

    // Reset asserted at E0+10 aborts the operation and clears outputs at once.
    a_in     = 32'h3FC00000;
    b_in     = 32'h40000000;
    start_in = 1'b1;
    @(posedge clock); #1;
    start_in = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_out), 32'd0);
    chk("abort_done", 32'(done_out), 32'd0);
    chk("abort_fpm", fpm_out, 32'd0);
    chk("abort_flags", 32'({overflow_out, underflow_out}), 32'd0);
    @(negedge clock);
    reset_n  = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done_out) saw_done = 1'b1;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);
    chk("abort_fpm_after", fpm_out, 32'd0);

    // The block is usable again after the abort.
    run_op(32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, -1, "post_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpm_seq_core.md
# fpm_seq_core

Multi-cycle, handshake-driven floating-point multiplier. It is the responder end of the operand/result exchange used by the floating-point multiplier bench: it accepts `a_in`/`b_in` on a start strobe and computes the product with an iterative shift-add mantissa multiplier. It returns `fpm_out`, `overflow_out` and `underflow_out` together with a one-cycle `done_out`. It is the area-lean alternative to the combinational multiplier and shares its operand format and flag semantics.

## Interface
- `EXP_WIDTH`, default 8: exponent field width; bias = 2^(EXP_WIDTH-1)-1.
- `MANTISSA_WIDTH`, default 23: stored fraction width (hidden bit implicit).
- `clock`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start_in`  in  1: request; sampled only in IDLE.
- `a_in`, `b_in`  in  EXP_WIDTH+MANTISSA_WIDTH+1 each: operands {sign, exp, frac}; latched on accepted start.
- `busy_out`  out  1: operation in flight.
- `done_out`  out  1: one-cycle pulse; result valid.
- `fpm_out`  out  EXP_WIDTH+MANTISSA_WIDTH+1: product; held until next result.
- `overflow_out`, `underflow_out`  out  1 each: flags for `fpm_out`; held with it.

## Operation
- FSM states: IDLE, MULT, NORM.
- IDLE, start_in=1 -> latch operands; set sign = sa^sb; set exp_sum = ea+eb-bias (signed, EXP_WIDTH+2 bits); load bit counter with MANTISSA_WIDTH; clear the 2*(MANTISSA_WIDTH+1)-bit accumulator; go to MULT.
- MULT: each cycle adds (multiplicand << i) if multiplier bit i is set, for i = 0..MANTISSA_WIDTH. Go to NORM after MANTISSA_WIDTH+1 cycles.
- NORM, single cycle: if product MSB = 1, shift right 1 and exp_sum+1. Apply rounding (see Configuration). If rounding carries out of the fraction, renormalize and exp_sum+1. Then classify, in priority order:
  - Either operand exp field = 0: result is signed zero (sign = sa^sb, exp=0, frac=0); both flags 0. Denormals are flushed to zero.
  - exp_sum >= 2^EXP_WIDTH-1: result is signed infinity (exp all ones, frac 0); overflow_out=1.
  - exp_sum <= 0: result is signed zero; underflow_out=1.
  - Otherwise: normal result; both flags 0.
  - Register the result and flags, pulse done_out, go to IDLE.
- Operands with exp all ones are treated as ordinary numbers; no NaN/Inf decoding.
- start_in while busy: ignored; no queueing.

## Timing
- Reset, applied asynchronously: state IDLE; busy_out=0, done_out=0, fpm_out=0, overflow_out=0, underflow_out=0; accumulator and counter cleared.
- Start accepted at edge E0.
  - busy_out=1 from E0 up to edge E0+MANTISSA_WIDTH+2.
  - done_out=1 for exactly the cycle following edge E0+MANTISSA_WIDTH+2. With defaults this is E0+25.
  - busy_out falls at the same edge where done_out rises.
- Result outputs update only at the done edge and are stable for the whole done cycle.
- start_in=1 during the done cycle is accepted. Back-to-back throughput is one result per MANTISSA_WIDTH+3 cycles.
- reset_n low mid-operation: the operation is aborted with no done_out. Outputs return to reset values immediately.

## Configuration
- `FPM_ROUND_EN` defined: round-to-nearest-even. Uses a guard bit, plus a sticky bit formed as the OR of all lower bits; ties round to even.
- `FPM_ROUND_EN` undefined: truncation (round toward zero). Guard and sticky logic is not instantiated. Latency is identical in both builds.

## Test plan
- Basic product: 0x3FC00000 × 0x40000000, start at E0 -> done_out at E0+25; fpm_out=0x40400000; flags 0; busy_out=0 afterwards.
- Sign: 0xC0000000 × 0x40400000 -> 0xC0C00000.
- Overflow: 0x7F000000 × 0x7F000000 -> 0x7F800000, overflow_out=1.
- Underflow: 0x00800000 × 0x00800000 -> 0x00000000, underflow_out=1.
- Zero input: 0x00000000 × 0xC0400000 -> 0x80000000, flags 0.
- Rounding and protocol:
  - 0x3F800001 × 0x3FC00000 -> 0x3FC00002 with `FPM_ROUND_EN`, 0x3FC00001 without.
  - A start pulsed while busy is ignored.
  - reset_n pulsed at E0+10 -> no done_out, all outputs 0.
